// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC controller.
package sar_pkg;

    localparam int SAR_BITS      = 10;
    localparam int STROBE_CYCLES = 2;
    localparam int SYNC_STAGES   = 2;

    // Mid-scale trial code: only the MSB set.
    localparam logic [SAR_BITS-1:0] DAC_MID = {1'b1, {(SAR_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        HOLD,
        STROBE
    } sar_state_e;

endpackage

// File: rtl/sar_comp_sync.sv
// Two-flop synchroniser for the asynchronous comparator decision.
module sar_comp_sync
    import sar_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample, 10-bit binary search, hold, strobe.
// Define SAR_CTRL_COMP_SYNC_EN to synchronise comparator_in and stretch each bit to 3 cycles.
module sar_ctrl
    import sar_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_conv_in,
    input  logic [3:0]          sample_cycles_in,
    input  logic                comparator_in,
    output logic                sample_n_out,
    output logic [SAR_BITS-1:0] dac_code_out,
    output logic [SAR_BITS-1:0] data_out,
    output logic                data_valid_strobe,
    output logic                busy_out
);

    localparam logic [3:0] MSB_IDX  = 4'(SAR_BITS - 1);
    localparam logic [1:0] STRB_END = 2'(STROBE_CYCLES - 1);

    sar_state_e          state_q, state_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic [3:0]          sval_q, sval_d;
    logic [3:0]          s_cnt_q, s_cnt_d;
    logic [1:0]          strb_cnt_q, strb_cnt_d;
    logic [SAR_BITS-1:0] code_q, code_d;
    logic [SAR_BITS-1:0] data_q, data_d;
    logic                sample_n_q, sample_n_d;
    logic                strobe_q, strobe_d;
    logic                busy_q, busy_d;

    logic comp_dec;
    logic decide;

`ifdef SAR_CTRL_COMP_SYNC_EN
    logic [1:0] phase_q, phase_d;

    sar_comp_sync u_comp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (comparator_in),
        .q_out (comp_dec)
    );

    // Each bit: drive code, two cycles for the synchroniser to catch up, then decide.
    assign decide = (phase_q == 2'd2);

    always_comb begin
        phase_d = 2'd0;
        if (state_q == CONVERT && !decide) begin
            phase_d = phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    assign comp_dec = comparator_in;
    assign decide   = 1'b1;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        sval_d     = sval_q;
        s_cnt_d    = s_cnt_q;
        strb_cnt_d = strb_cnt_q;
        code_d     = code_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (start_conv_in) begin
                    state_d = SAMPLE;
                    sval_d  = sample_cycles_in;
                    s_cnt_d = 4'd0;
                    code_d  = DAC_MID;
                end
            end
            SAMPLE: begin
                if (s_cnt_q == sval_q) begin
                    state_d   = CONVERT;
                    bit_idx_d = MSB_IDX;
                end else begin
                    s_cnt_d = s_cnt_q + 4'd1;
                end
            end
            CONVERT: begin
                if (decide) begin
                    if (!comp_dec) begin
                        code_d[bit_idx_q] = 1'b0;
                    end
                    if (bit_idx_q == 4'd0) begin
                        data_d  = code_d;
                        state_d = HOLD;
                    end else begin
                        code_d[bit_idx_q - 4'd1] = 1'b1;
                        bit_idx_d = bit_idx_q - 4'd1;
                    end
                end
            end
            HOLD: begin
                state_d    = STROBE;
                strb_cnt_d = 2'd0;
            end
            STROBE: begin
                if (strb_cnt_q == STRB_END) begin
                    if (start_conv_in) begin
                        state_d = SAMPLE;
                        sval_d  = sample_cycles_in;
                        s_cnt_d = 4'd0;
                        code_d  = DAC_MID;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    strb_cnt_d = strb_cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        sample_n_d = (state_d != SAMPLE);
        strobe_d   = (state_d == STROBE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_idx_q  <= MSB_IDX;
            sval_q     <= 4'd0;
            s_cnt_q    <= 4'd0;
            strb_cnt_q <= 2'd0;
            code_q     <= '0;
            data_q     <= '0;
            sample_n_q <= 1'b1;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            sval_q     <= sval_d;
            s_cnt_q    <= s_cnt_d;
            strb_cnt_q <= strb_cnt_d;
            code_q     <= code_d;
            data_q     <= data_d;
            sample_n_q <= sample_n_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
        end
    end

    assign sample_n_out      = sample_n_q;
    assign dac_code_out      = code_q;
    assign data_out          = data_q;
    assign data_valid_strobe = strobe_q;
    assign busy_out          = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl; a threshold comparator model stands in for the analogue side.
module tb_sar_ctrl;

`ifdef SAR_CTRL_COMP_SYNC_EN
    localparam int BIT_CYC = 3;
`else
    localparam int BIT_CYC = 1;
`endif
    localparam int CONV = 10 * BIT_CYC;
    localparam int LOAD = 1 + CONV;          // data_out load edge for S=1, start at edge 0
    localparam int NREC = 128;

    logic       clk;
    logic       rst_n;
    logic       start_conv_in;
    logic [3:0] sample_cycles_in;
    logic       comparator_in;
    logic       sample_n_out;
    logic [9:0] dac_code_out;
    logic [9:0] data_out;
    logic       data_valid_strobe;
    logic       busy_out;
    logic [9:0] thr;

    int checks = 0;
    int errors = 0;

    logic       rec_sn   [0:NREC-1];
    logic [9:0] rec_dac  [0:NREC-1];
    logic [9:0] rec_data [0:NREC-1];
    logic       rec_strb [0:NREC-1];
    logic       rec_busy [0:NREC-1];

    sar_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_conv_in     (start_conv_in),
        .sample_cycles_in  (sample_cycles_in),
        .comparator_in     (comparator_in),
        .sample_n_out      (sample_n_out),
        .dac_code_out      (dac_code_out),
        .data_out          (data_out),
        .data_valid_strobe (data_valid_strobe),
        .busy_out          (busy_out)
    );

    assign comparator_in = (thr >= dac_code_out);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise start, then record outputs 1 time unit after each of n edges (index 0 = accept edge).
    task automatic run(input logic [9:0] t1, input logic [9:0] t2, input int t2_edge,
                       input logic [3:0] sval, input int release_edge, input bit scramble,
                       input int n);
        thr              = t1;
        sample_cycles_in = sval;
        start_conv_in    = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rec_sn[k]   = sample_n_out;
            rec_dac[k]  = dac_code_out;
            rec_data[k] = data_out;
            rec_strb[k] = data_valid_strobe;
            rec_busy[k] = busy_out;
            if (k == release_edge) start_conv_in = 1'b0;
            if (k == t2_edge) thr = t2;
            if (scramble && k == 0) sample_cycles_in = ~sval;
        end
    endtask

    initial begin
        int cnt;
        int first;
        clk              = 1'b0;
        rst_n            = 1'b0;
        start_conv_in    = 1'b0;
        sample_cycles_in = 4'd0;
        thr              = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample_n", sample_n_out, 1'b1);
        check("rst_dac", dac_code_out, 10'h000);
        check("rst_data", data_out, 10'h000);
        check("rst_strobe", data_valid_strobe, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Threshold 2A5, S=1, single pulse.
        run(10'h2A5, 10'h000, -1, 4'd0, 0, 1'b0, LOAD + 6);
        check("t1_sn0", rec_sn[0], 1'b0);
        check("t1_sn1", rec_sn[1], 1'b1);
        check("t1_dac0", rec_dac[0], 10'h200);
        check("t1_data_pre", rec_data[LOAD-1], 10'h000);
        check("t1_data", rec_data[LOAD], 10'h2A5);
        check("t1_strb_hold", rec_strb[LOAD], 1'b0);
        check("t1_strb_a", rec_strb[LOAD+1], 1'b1);
        check("t1_strb_b", rec_strb[LOAD+2], 1'b1);
        check("t1_strb_end", rec_strb[LOAD+3], 1'b0);
        check("t1_busy_strb", rec_busy[LOAD+2], 1'b1);
        check("t1_busy_end", rec_busy[LOAD+3], 1'b0);

        // Comparator always 1.
        run(10'h3FF, 10'h000, -1, 4'd0, 0, 1'b0, LOAD + 6);
        check("all1_data", rec_data[LOAD], 10'h3FF);

        // Comparator always 0: trial codes walk down one bit at a time.
        run(10'h000, 10'h000, -1, 4'd0, 0, 1'b0, LOAD + 6);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("all0_dac%0d", i), rec_dac[1 + i*BIT_CYC], 10'h200 >> i);
        end
        check("all0_data", rec_data[LOAD], 10'h000);
        check("all0_data_pre", rec_data[LOAD-1], 10'h3FF);

        // S=16; sample_cycles_in changed after acceptance must not matter.
        run(10'h0F0, 10'h000, -1, 4'd15, 0, 1'b1, LOAD + 22);
        cnt   = 0;
        first = -1;
        for (int k = 0; k < LOAD + 22; k++) begin
            if (!rec_sn[k]) cnt++;
            if (rec_strb[k] && first < 0) first = k;
        end
        check("s16_sample_len", cnt, 16);
        check("s16_strb_rise", first, LOAD + 16);
        check("s16_data", rec_data[LOAD+15], 10'h0F0);

        // Back-to-back: start held through the first strobe.
        run(10'h001, 10'h3FE, LOAD + 1, 4'd0, LOAD + 4, 1'b0, 2*LOAD + 8);
        cnt = 0;
        for (int k = 0; k <= 2*LOAD + 5; k++) begin
            if (!rec_busy[k]) cnt++;
        end
        check("b2b_busy_gaps", cnt, 0);
        check("b2b_data1", rec_data[LOAD], 10'h001);
        check("b2b_data1_strb", rec_data[LOAD+1], 10'h001);
        check("b2b_strb1", rec_strb[LOAD+1], 1'b1);
        check("b2b_resample", rec_sn[LOAD+3], 1'b0);
        check("b2b_data2", rec_data[2*LOAD+3], 10'h3FE);
        check("b2b_data2_strb", rec_data[2*LOAD+4], 10'h3FE);
        check("b2b_strb2", rec_strb[2*LOAD+4], 1'b1);
        check("b2b_idle", rec_busy[2*LOAD+6], 1'b0);

        // Threshold 155.
        run(10'h155, 10'h000, -1, 4'd0, 0, 1'b0, LOAD + 6);
        check("t155_data", rec_data[LOAD], 10'h155);
        check("t155_strb", rec_strb[LOAD+1], 1'b1);

        // Reset asserted while bit 5 is on trial.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(10'h2A5, 10'h000, -1, 4'd0, 0, 1'b0, 1 + 4*BIT_CYC + 1);
        check("rst_mid_dac", rec_dac[1 + 4*BIT_CYC], 10'h2A0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstc_sample_n", sample_n_out, 1'b1);
        check("rstc_dac", dac_code_out, 10'h000);
        check("rstc_data", data_out, 10'h000);
        check("rstc_strobe", data_valid_strobe, 1'b0);
        check("rstc_busy", busy_out, 1'b0);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < LOAD + 8; k++) begin
            @(posedge clk);
            #1;
            if (data_valid_strobe || busy_out || data_out != 10'h000) cnt++;
        end
        check("rstc_quiet", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
